// File: rtl/pulse_rate_meter_if.sv
// Tick input and measurement results of the pulse rate meter.
// The tick source drives PulseIn; the meter drives everything else.
interface pulse_rate_meter_if #(
  parameter int unsigned CNT_W = 28
);
  logic             PulseIn;
  logic [1:0]       SpeedCode;
  logic             SpeedValid;
  logic [CNT_W-1:0] PeriodCount;
  logic             Mismatch;
  logic             Timeout;
  logic [3:0]       EdgeCount;

  modport master (
    output PulseIn,
    input  SpeedCode, SpeedValid, PeriodCount, Mismatch, Timeout, EdgeCount
  );

  modport slave (
    input  PulseIn,
    output SpeedCode, SpeedValid, PeriodCount, Mismatch, Timeout, EdgeCount
  );
endinterface

// File: rtl/pulse_rate_meter.sv
// Measures the period between rising edges of a tick stream and recovers the
// Speed setting (always-on, F, 2F or 4F cycles) that produced it.
module pulse_rate_meter #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned TOL             = 0,
  parameter int unsigned CNT_W           = 28
) (
  input  logic              ClockIn,
  input  logic              Reset,
  pulse_rate_meter_if.slave bus
);
  typedef enum logic [1:0] {ARMED = 2'd0, MEASURE = 2'd1, HOLD = 2'd2} state_t;

  localparam longint F      = longint'(CLOCK_FREQUENCY);
  localparam longint T      = longint'(TOL);
  localparam longint ZERO_L = 0;
  localparam longint ONE_L  = 1;
  // Lower window edges are clamped so a large TOL cannot wrap below zero.
  localparam longint W1_LO_L = (F - T < ONE_L) ? ONE_L : F - T;
  localparam longint W2_LO_L = (2 * F - T < ZERO_L) ? ZERO_L : 2 * F - T;
  localparam longint W4_LO_L = (4 * F - T < ZERO_L) ? ZERO_L : 4 * F - T;
  localparam longint W1_HI_L = F + T;
  localparam longint W2_HI_L = 2 * F + T;
  localparam longint W4_HI_L = 4 * F + T;
  localparam longint TO_L    = 4 * F + T + 1;

  localparam logic [CNT_W-1:0] W1_LO   = W1_LO_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] W2_LO   = W2_LO_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] W4_LO   = W4_LO_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] W1_HI   = W1_HI_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] W2_HI   = W2_HI_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] W4_HI   = W4_HI_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] TO_CNT  = TO_L[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             prev_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       speed_q, speed_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mismatch_q, mismatch_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       edge_q, edge_d;

  logic rise, high2, timeout_hit;
  logic match1, match2, match4;

  assign rise        = bus.PulseIn & ~prev_q;
  assign high2       = bus.PulseIn & prev_q;
  assign timeout_hit = ~bus.PulseIn && (count_q == TO_CNT);

  // On a rise count_q holds the period P since the previous rise.
  assign match1 = (count_q >= W1_LO) && (count_q <= W1_HI);
  assign match2 = (count_q >= W2_LO) && (count_q <= W2_HI);
  assign match4 = (count_q >= W4_LO) && (count_q <= W4_HI);

  always_comb begin
    if (rise)
      count_d = CNT_ONE;
    else if (&count_q)
      count_d = count_q;
    else
      count_d = count_q + CNT_ONE;
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q    <= ARMED;
      prev_q     <= 1'b0;
      count_q    <= '0;
      speed_q    <= 2'b00;
      valid_q    <= 1'b0;
      period_q   <= '0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      edge_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= bus.PulseIn;
      count_q    <= count_d;
      speed_q    <= speed_d;
      valid_q    <= valid_d;
      period_q   <= period_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
      edge_q     <= edge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED, MEASURE: begin
        if (rise)
          state_d = MEASURE;
        else if (high2)
          state_d = HOLD;
        else if (timeout_hit)
          state_d = ARMED;
      end
      HOLD: begin
        if (!bus.PulseIn)
          state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  // A rise in ARMED only re-arms; classification needs a prior edge.
  always_comb begin
    speed_d    = speed_q;
    valid_d    = valid_q;
    period_d   = period_q;
    mismatch_d = mismatch_q;
    timeout_d  = timeout_q;
    edge_d     = edge_q;
    case (state_q)
      ARMED, MEASURE: begin
        if (rise) begin
          edge_d = edge_q + 4'd1;
          if (state_q == ARMED) begin
            timeout_d = 1'b0;
          end else begin
            period_d = count_q;
            if (match1 || match2 || match4) begin
              valid_d    = 1'b1;
              mismatch_d = 1'b0;
              speed_d    = match1 ? 2'b01 : (match2 ? 2'b10 : 2'b11);
            end else begin
              valid_d    = 1'b0;
              mismatch_d = 1'b1;
            end
          end
        end else if (high2) begin
          speed_d    = 2'b00;
          valid_d    = 1'b1;
          mismatch_d = 1'b0;
          timeout_d  = 1'b0;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          valid_d   = 1'b0;
        end
      end
      HOLD: begin
        if (!bus.PulseIn)
          valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.SpeedCode   = speed_q;
  assign bus.SpeedValid  = valid_q;
  assign bus.PeriodCount = period_q;
  assign bus.Mismatch    = mismatch_q;
  assign bus.Timeout     = timeout_q;
  assign bus.EdgeCount   = edge_q;
endmodule
